// File: rtl/fp8_to_int_line_reader_if.sv
// Handshake/data bundle for the FP8 line-buffer read side.
// Define FP8_NAN_FLAG_EN to add the per-lane NaN flag output.
interface fp8_to_int_line_reader_if #(
    parameter int int_bits = 20
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_fp8_0;
    logic [7:0]          in_fp8_1;
    logic [int_bits-1:0] in_int_2;
    logic                out_valid;
    logic                out_ready;
    logic [int_bits-1:0] out_0;
    logic [int_bits-1:0] out_1;
    logic [int_bits-1:0] out_2;
`ifdef FP8_NAN_FLAG_EN
    logic [1:0]          out_nan;

    modport master (
        output in_valid, in_fp8_0, in_fp8_1, in_int_2, out_ready,
        input  in_ready, out_valid, out_0, out_1, out_2, out_nan
    );
    modport slave (
        input  in_valid, in_fp8_0, in_fp8_1, in_int_2, out_ready,
        output in_ready, out_valid, out_0, out_1, out_2, out_nan
    );
`else
    modport master (
        output in_valid, in_fp8_0, in_fp8_1, in_int_2, out_ready,
        input  in_ready, out_valid, out_0, out_1, out_2
    );
    modport slave (
        input  in_valid, in_fp8_0, in_fp8_1, in_int_2, out_ready,
        output in_ready, out_valid, out_0, out_1, out_2
    );
`endif
endinterface

// File: rtl/fp8_to_int_line_reader.sv
// Two-stage FP8 (E4M3) -> signed integer decoder with lane-2 passthrough, valid/ready both sides.
// Optional macro FP8_NAN_FLAG_EN adds a pipelined per-lane NaN flag (out_nan).
module fp8_to_int_line_reader #(
    parameter int int_bits = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    fp8_to_int_line_reader_if.slave   bus
);
    logic                         s2_load;
    logic                         s1_load;

    logic [1:0][7:0]              fp8_in;
    logic [1:0]                   dec_sign;
    logic [1:0][3:0]              dec_shift;
    logic [1:0][3:0]              dec_sig;
    logic [1:0][int_bits-1:0]     s2_val;

    logic                         s1_valid_q, s1_valid_d;
    logic [1:0]                   s1_sign_q,  s1_sign_d;
    logic [1:0][3:0]              s1_shift_q, s1_shift_d;
    logic [1:0][3:0]              s1_sig_q,   s1_sig_d;
    logic [int_bits-1:0]          s1_int2_q,  s1_int2_d;

    logic                         out_valid_q, out_valid_d;
    logic [1:0][int_bits-1:0]     out_lane_q,  out_lane_d;
    logic [int_bits-1:0]          out_int2_q,  out_int2_d;

`ifdef FP8_NAN_FLAG_EN
    logic [1:0]                   dec_nan;
    logic [1:0]                   s1_nan_q,  s1_nan_d;
    logic [1:0]                   out_nan_q, out_nan_d;
`endif

    assign s2_load = !out_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign fp8_in  = {bus.in_fp8_1, bus.in_fp8_0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [3:0]          exp_f;
            logic [2:0]          man_f;
            logic                is_nan;
            logic [int_bits-1:0] sig_ext;
            logic [int_bits-1:0] mag;

            assign exp_f  = fp8_in[gi][6:3];
            assign man_f  = fp8_in[gi][2:0];
            assign is_nan = (exp_f == 4'hF) && (man_f == 3'h7);

            // Subnormals shift as exp=1; NaN zeroes its significand so it decodes to 0.
            assign dec_sign[gi]  = fp8_in[gi][7];
            assign dec_shift[gi] = (exp_f == 4'd0) ? 4'd1 : exp_f;
            assign dec_sig[gi]   = is_nan ? 4'd0 : {(exp_f != 4'd0), man_f};
`ifdef FP8_NAN_FLAG_EN
            assign dec_nan[gi]   = is_nan;
`endif

            // value = sig * 2^(exp-10); right shift truncates toward zero on the magnitude
            assign sig_ext = {{(int_bits-4){1'b0}}, s1_sig_q[gi]};
            assign mag     = (s1_shift_q[gi] >= 4'd10)
                           ? (sig_ext << (s1_shift_q[gi] - 4'd10))
                           : (sig_ext >> (4'd10 - s1_shift_q[gi]));
            assign s2_val[gi] = s1_sign_q[gi] ? -mag : mag;
        end
    endgenerate

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_shift_d  = s1_shift_q;
        s1_sig_d    = s1_sig_q;
        s1_int2_d   = s1_int2_q;
        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        out_int2_d  = out_int2_q;
`ifdef FP8_NAN_FLAG_EN
        s1_nan_d    = s1_nan_q;
        out_nan_d   = out_nan_q;
`endif
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d  = dec_sign;
                s1_shift_d = dec_shift;
                s1_sig_d   = dec_sig;
                s1_int2_d  = bus.in_int_2;
`ifdef FP8_NAN_FLAG_EN
                s1_nan_d   = dec_nan;
`endif
            end
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_lane_d = s2_val;
                out_int2_d = s1_int2_q;
`ifdef FP8_NAN_FLAG_EN
                out_nan_d  = s1_nan_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= '0;
            s1_shift_q  <= '0;
            s1_sig_q    <= '0;
            s1_int2_q   <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_int2_q  <= '0;
`ifdef FP8_NAN_FLAG_EN
            s1_nan_q    <= '0;
            out_nan_q   <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_shift_q  <= s1_shift_d;
            s1_sig_q    <= s1_sig_d;
            s1_int2_q   <= s1_int2_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_int2_q  <= out_int2_d;
`ifdef FP8_NAN_FLAG_EN
            s1_nan_q    <= s1_nan_d;
            out_nan_q   <= out_nan_d;
`endif
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_0     = out_lane_q[0];
    assign bus.out_1     = out_lane_q[1];
    assign bus.out_2     = out_int2_q;
`ifdef FP8_NAN_FLAG_EN
    assign bus.out_nan   = out_nan_q;
`endif

endmodule
